// File: rtl/complex_div_seq.sv
// Sequential radix-2 restoring divider: quotient = (im << P_FRAC_W) / real, plus remainder.
// Optional round-half-away-from-zero in the final stage when COMPLEX_DIV_ROUND_EN is defined.
module complex_div_seq #(
  parameter int P_DATA_W = 32,
  parameter int P_FRAC_W = 8,
  parameter int P_SIGNED = 1
) (
  input  logic                clk_ir,
  input  logic                rst_il,
  input  logic [P_DATA_W-1:0] real_id,
  input  logic [P_DATA_W-1:0] im_id,
  input  logic                start_ip,
  output logic                rdy_od,
  output logic [P_DATA_W-1:0] res_q_od,
  output logic [P_DATA_W-1:0] res_r_od,
  output logic                res_valid_od,
  output logic                div_zero_od,
  output logic                ovrflw_od
);

  // state | meaning
  // IDLE  | ready, operands latched on start_ip
  // CALC  | one restoring step per clock, N clocks
  // DONE  | sign/saturation applied, outputs registered
  localparam int W  = P_DATA_W;
  localparam int N  = P_DATA_W + P_FRAC_W;
  localparam int CW = $clog2(N + 1);

  localparam logic [N:0]   ONE     = {{N{1'b0}}, 1'b1};
  localparam logic [N:0]   LIM_POS = (P_SIGNED != 0) ? (ONE << (W - 1)) - ONE : (ONE << W) - ONE;
  localparam logic [N:0]   LIM_NEG = ONE << (W - 1);
  localparam logic [W-1:0] SAT_MAX = (P_SIGNED != 0) ? {1'b0, {(W - 1){1'b1}}} : {W{1'b1}};
  localparam logic [W-1:0] SAT_MIN = {1'b1, {(W - 1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state, state_nxt;
  logic [N-1:0]    dvd;
  logic [W-1:0]    rem;
  logic [W-1:0]    dvs;
  logic [CW-1:0]   cnt;
  logic            sign_n, sign_d, zero_d, zero_n;

  logic [W-1:0]    mag_im, mag_re;
  logic [N-1:0]    dvd_init;
  logic [W:0]      rem_sh, diff;
  logic [N:0]      qmag;
  logic [W-1:0]    q_fin, r_fin;
  logic            ovf_fin, neg;

  function automatic logic [W-1:0] mag(input logic [W-1:0] v);
    return ((P_SIGNED != 0) && v[W-1]) ? (~v + 1'b1) : v;
  endfunction

  assign mag_im   = mag(im_id);
  assign mag_re   = mag(real_id);
  assign dvd_init = N'(mag_im) << P_FRAC_W;
  assign rdy_od   = (state == IDLE);

  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ip) state_nxt = CALC;
      CALC:    if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // diff[W] is the borrow: set means the trial subtraction went negative
  always_comb begin
    rem_sh = {rem, dvd[N-1]};
    diff   = rem_sh - {1'b0, dvs};
  end

  always_comb begin
    qmag = {1'b0, dvd};
`ifdef COMPLEX_DIV_ROUND_EN
    if (!zero_d && ({rem, 1'b0} >= {1'b0, dvs})) qmag = qmag + ONE;
`endif
    neg     = sign_n ^ sign_d;
    q_fin   = qmag[W-1:0];
    r_fin   = sign_n ? (~rem + 1'b1) : rem;
    ovf_fin = 1'b0;
    if (zero_d) begin
      q_fin = zero_n ? '0 : (sign_n ? SAT_MIN : SAT_MAX);
      r_fin = '0;
    end else if (neg) begin
      if (qmag > LIM_NEG) begin
        q_fin   = SAT_MIN;
        ovf_fin = 1'b1;
      end else begin
        q_fin = ~qmag[W-1:0] + 1'b1;
      end
    end else if (qmag > LIM_POS) begin
      q_fin   = SAT_MAX;
      ovf_fin = 1'b1;
    end
  end

  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      dvd          <= '0;
      rem          <= '0;
      dvs          <= '0;
      cnt          <= '0;
      sign_n       <= 1'b0;
      sign_d       <= 1'b0;
      zero_d       <= 1'b0;
      zero_n       <= 1'b0;
      res_q_od     <= '0;
      res_r_od     <= '0;
      res_valid_od <= 1'b0;
      div_zero_od  <= 1'b0;
      ovrflw_od    <= 1'b0;
    end else begin
      res_valid_od <= 1'b0;
      case (state)
        IDLE: if (start_ip) begin
          dvd    <= dvd_init;
          rem    <= '0;
          dvs    <= mag_re;
          cnt    <= CW'(N - 1);
          sign_n <= (P_SIGNED != 0) && im_id[W-1];
          sign_d <= (P_SIGNED != 0) && real_id[W-1];
          zero_d <= (real_id == '0);
          zero_n <= (im_id == '0);
        end
        CALC: begin
          rem <= diff[W] ? rem_sh[W-1:0] : diff[W-1:0];
          dvd <= {dvd[N-2:0], ~diff[W]};
          cnt <= cnt - 1'b1;
        end
        DONE: begin
          res_q_od     <= q_fin;
          res_r_od     <= r_fin;
          div_zero_od  <= zero_d;
          ovrflw_od    <= ovf_fin;
          res_valid_od <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
